sprite_row_serializer: RTL and testbench
========================================

// Module: sprite_row_serializer
// PURPOSE
//  Downstream consumer of the 96-bit sprite/board ROM. Accepts a row-address request, drives the
//  ROM address, captures the registered ROM word one cycle later and serializes it MSB-first as a
//  1-bit pixel stream (valid/ready) toward the VGA pixel mux. Each bit is optionally repeated
//  SCALE times for horizontal upscaling of board cells and X/O glyphs.
// PARAMETERS
//  DATA_WIDTH  96  ROM word width = pixels per sprite row
//  ADDR_WIDTH  12  ROM address width
//  SCALE       1   emissions per bit (legal 1..16); stream length = DATA_WIDTH*SCALE
// PORTS
//  clk        in   1           system clock, all logic on posedge
//  rst_n      in   1           synchronous active-low reset, sampled on posedge clk
//  req_valid  in   1           row request valid
//  req_ready  out  1           block idle, can accept request
//  req_addr   in   ADDR_WIDTH  ROM row address of request
//  rom_addr   out  ADDR_WIDTH  address to ROM (registered)
//  rom_q      in   DATA_WIDTH  ROM data; valid the cycle after ROM samples rom_addr
//  pix_valid  out  1           pix_bit valid
//  pix_ready  in   1           downstream accepts pixel
//  pix_bit    out  1           current pixel (1 = foreground)
//  pix_last   out  1           final emission of the row
//  busy       out  1           request in progress (state != IDLE)
// BEHAVIOUR
//  - One clock (clk); reset synchronous, active-low (rst_n). Reset wins over all other events.
//  - Reset values: state IDLE, req_ready 1, rom_addr 0, pix_valid 0, pix_bit 0, pix_last 0, busy 0,
//    shift register 0, bit counter 0, repeat counter 0.
//  - FSM: IDLE -> WAIT -> LOAD -> SHIFT -> IDLE.
//    IDLE : req_ready=1. On req_valid&req_ready at edge T: rom_addr<=req_addr, go WAIT.
//    WAIT : ROM samples rom_addr at edge T+1; go LOAD.
//    LOAD : rom_q valid; at edge T+2 shift reg<=rom_q, bit_cnt<=0, rep_cnt<=0, go SHIFT.
//    SHIFT: pix_valid=1, pix_bit=shreg[DATA_WIDTH-1]. On pix_valid&pix_ready: if rep_cnt<SCALE-1
//           rep_cnt++; else rep_cnt<=0, shreg<<=1, bit_cnt++. On the handshake with pix_last, go IDLE.
//  - Latency: accept edge T -> first pix_valid visible in cycle after edge T+2 (3 edges incl. T).
//  - pix_last = SHIFT & bit_cnt==DATA_WIDTH-1 & rep_cnt==SCALE-1 (combinational from state/counters).
//  - Stall: pix_ready=0 holds pix_bit, pix_last, counters and shreg unchanged; pix_valid stays 1.
//  - req_ready=0 in WAIT/LOAD/SHIFT; req_valid there is ignored (not queued). rom_addr holds its
//    value outside the accept edge. Next request earliest accepted the cycle after final handshake.
//  - Bit order: rom_q[DATA_WIDTH-1] is leftmost pixel, emitted first; rom_q[0] emitted last.
//  - Counters: bit_cnt width $clog2(DATA_WIDTH), rep_cnt width $clog2(SCALE)+1; no wrap beyond
//    DATA_WIDTH-1 / SCALE-1 (FSM leaves SHIFT).
//  - Reset mid-operation (any state): next edge returns to reset values; no further pix_valid, the
//    interrupted row is dropped, no partial resume.
//  - Outputs pix_valid/pix_bit/pix_last derive only from registered state (no req_* -> pix_* path).
// TESTING (bench ROM model: registered read, rom[5]=96'hF000...0001, rom[7]=all ones)
//  1 reset: rst_n=0 3 cycles -> req_ready=1, pix_valid=0, rom_addr=0, busy=0; then release, idle.
//  2 req_addr=5, pix_ready=1, SCALE=1 -> first pix_valid 3 edges after accept; bits 1,1,1,1 then
//    91 zeros, last bit 1 with pix_last=1 on emission 96; req_ready=1 next cycle.
//  3 req_addr=7, pix_ready toggled 1/0 each cycle -> 96 ones emitted, pix_bit/pix_last stable
//    during stalls, total 96 handshakes, exactly one pix_last.
//  4 SCALE=3, req_addr=5 -> 288 emissions; first 12 are 1, last 3 are 1, pix_last only on 288th.
//  5 req_valid held high during SHIFT with req_addr=7 -> ignored; row 5 completes unchanged,
//    then row 7 accepted the cycle after pix_last handshake.
//  6 rst_n=0 for 1 cycle at emission 40 of row 7 -> pix_valid=0 next cycle, state IDLE, no pix_last.

Source files
------------

// File: rtl/sprite_row_serializer.sv
// Purpose : fetch one sprite/board ROM row and stream it MSB-first as 1-bit pixels,
//           with each bit repeated SCALE times for horizontal upscaling.
// Latency : request accepted at edge T -> first pix_valid in the cycle after edge T+2.
// Backpr. : pix_ready=0 freezes pixel, counters and shift register; new requests are
//           refused (not queued) until the row's final handshake.
// Ports   : clk/rst_n (sync active-low); req_valid/req_ready/req_addr row request;
//           rom_addr/rom_q registered ROM interface; pix_valid/pix_ready/pix_bit/pix_last
//           pixel stream; busy = request in progress.
module sprite_row_serializer #(
  parameter int DATA_WIDTH = 96,
  parameter int ADDR_WIDTH = 12,
  parameter int SCALE      = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_q,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic                  pix_bit,
  output logic                  pix_last,
  output logic                  busy
);

  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int REP_W = $clog2(SCALE) + 1;
  localparam logic [BIT_W-1:0] BIT_MAX = BIT_W'(DATA_WIDTH - 1);
  localparam logic [REP_W-1:0] REP_MAX = REP_W'(SCALE - 1);

  typedef enum logic [1:0] {IDLE, WAIT, LOAD, SHIFT} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] rom_addr_nxt;
  logic [DATA_WIDTH-1:0] shreg, shreg_nxt;
  logic [BIT_W-1:0]      bit_cnt, bit_cnt_nxt;
  logic [REP_W-1:0]      rep_cnt, rep_cnt_nxt;
  logic                  pix_fire;

  // Pixel-side outputs come only from registered state, so there is no
  // combinational path from the request inputs to the pixel stream.
  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign pix_valid = (state == SHIFT);
  assign pix_bit   = shreg[DATA_WIDTH-1];
  assign pix_last  = (state == SHIFT) && (bit_cnt == BIT_MAX) && (rep_cnt == REP_MAX);
  assign pix_fire  = pix_valid && pix_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      rom_addr <= '0;
      shreg    <= '0;
      bit_cnt  <= '0;
      rep_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      rom_addr <= rom_addr_nxt;
      shreg    <= shreg_nxt;
      bit_cnt  <= bit_cnt_nxt;
      rep_cnt  <= rep_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    rom_addr_nxt = rom_addr;
    shreg_nxt    = shreg;
    bit_cnt_nxt  = bit_cnt;
    rep_cnt_nxt  = rep_cnt;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          rom_addr_nxt = req_addr;
          state_nxt    = WAIT;
        end
      end
      // ROM registers rom_addr on this edge; its word is on rom_q during LOAD.
      WAIT: state_nxt = LOAD;
      LOAD: begin
        shreg_nxt   = rom_q;
        bit_cnt_nxt = '0;
        rep_cnt_nxt = '0;
        state_nxt   = SHIFT;
      end
      SHIFT: begin
        if (pix_fire) begin
          if (pix_last) begin
            // Counters park at zero instead of stepping past the row end.
            shreg_nxt   = {shreg[DATA_WIDTH-2:0], 1'b0};
            bit_cnt_nxt = '0;
            rep_cnt_nxt = '0;
            state_nxt   = IDLE;
          end else if (rep_cnt != REP_MAX) begin
            rep_cnt_nxt = rep_cnt + 1'b1;
          end else begin
            rep_cnt_nxt = '0;
            shreg_nxt   = {shreg[DATA_WIDTH-2:0], 1'b0};
            bit_cnt_nxt = bit_cnt + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sprite_row_serializer.sv
module tb_sprite_row_serializer;
  localparam int DW = 96;
  localparam int AW = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, req_valid, pix_ready, req_ready, pix_valid, pix_bit, pix_last, busy;
  logic [AW-1:0] req_addr, rom_addr;
  logic [DW-1:0] rom_q;
  logic          req_valid3, pix_ready3, req_ready3, pix_valid3, pix_bit3, pix_last3, busy3;
  logic [AW-1:0] req_addr3, rom_addr3;
  logic [DW-1:0] rom_q3;

  sprite_row_serializer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SCALE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .rom_addr(rom_addr), .rom_q(rom_q), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .pix_bit(pix_bit), .pix_last(pix_last), .busy(busy));

  sprite_row_serializer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SCALE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_addr(req_addr3), .rom_addr(rom_addr3), .rom_q(rom_q3), .pix_valid(pix_valid3),
    .pix_ready(pix_ready3), .pix_bit(pix_bit3), .pix_last(pix_last3), .busy(busy3));

  // Registered-read ROM model.
  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    case (a)
      12'd5:   rom_word = {4'hF, 91'b0, 1'b1};
      12'd7:   rom_word = '1;
      default: rom_word = '0;
    endcase
  endfunction

  always @(posedge clk) begin
    rom_q  <= rom_word(rom_addr);
    rom_q3 <= rom_word(rom_addr3);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timeout at cycle %0d", name, cyc);
  endtask

  // Scoreboard: {bit, last} per expected emission.
  logic [1:0] q1[$];
  logic [1:0] q3[$];

  task automatic push_row(input int sel, input logic [AW-1:0] a, input int scale);
    logic [DW-1:0] w;
    w = rom_word(a);
    for (int i = DW - 1; i >= 0; i--)
      for (int r = 0; r < scale; r++)
        if (sel == 1) q1.push_back({w[i], (i == 0 && r == scale - 1)});
        else          q3.push_back({w[i], (i == 0 && r == scale - 1)});
  endtask

  int   hs1 = 0, last1 = 0, last_edge1 = 0, acc_edge1 = 0, fv_edge1 = 0;
  int   hs3 = 0, last3 = 0;
  bit   acc_seen1 = 0, acc_seen3 = 0, prev_v1 = 0, stl1 = 0;
  logic st_bit, st_last;
  logic [1:0] e;

  // Monitor for the SCALE=1 instance.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && stl1) begin
      check("stall_valid", pix_valid, 1);
      check("stall_bit", pix_bit, st_bit);
      check("stall_last", pix_last, st_last);
    end
    stl1    = (rst_n === 1'b1) && pix_valid && !pix_ready;
    st_bit  = pix_bit;
    st_last = pix_last;
    if (rst_n === 1'b1 && req_valid && req_ready) begin
      acc_seen1 = 1;
      acc_edge1 = cyc + 1;
    end
    if (pix_valid === 1'b1 && !prev_v1) fv_edge1 = cyc;
    prev_v1 = (pix_valid === 1'b1);
    if (pix_valid === 1'b1 && pix_ready) begin
      if (q1.size() == 0) timeout("unexpected_pixel_dut1");
      else begin
        e = q1.pop_front();
        check("pix_bit_dut1", pix_bit, e[1]);
        check("pix_last_dut1", pix_last, e[0]);
      end
      hs1++;
      if (pix_last) begin
        last1++;
        last_edge1 = cyc + 1;
      end
    end
  end

  // Monitor for the SCALE=3 instance.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && req_valid3 && req_ready3) acc_seen3 = 1;
    if (pix_valid3 === 1'b1 && pix_ready3) begin
      if (q3.size() == 0) timeout("unexpected_pixel_dut3");
      else begin
        e = q3.pop_front();
        check("pix_bit_dut3", pix_bit3, e[1]);
        check("pix_last_dut3", pix_last3, e[0]);
      end
      hs3++;
      if (pix_last3) last3++;
    end
  end

  task automatic send(input int sel, input logic [AW-1:0] a);
    int n = 0;
    push_row(sel, a, (sel == 1) ? 1 : 3);
    if (sel == 1) begin acc_seen1 = 0; req_addr  = a; req_valid  = 1; end
    else          begin acc_seen3 = 0; req_addr3 = a; req_valid3 = 1; end
    forever begin
      @(posedge clk); #1;
      if ((sel == 1) ? acc_seen1 : acc_seen3) break;
      if (++n > 50) begin timeout("accept"); break; end
    end
    req_valid  = 0;
    req_valid3 = 0;
  endtask

  task automatic wait_idle(input int sel, input bit tog, input int budget);
    int n = 0;
    forever begin
      @(posedge clk); #1;
      if (tog) pix_ready = ~pix_ready;
      if (sel == 1 ? (q1.size() == 0 && !pix_valid) : (q3.size() == 0 && !pix_valid3)) break;
      if (++n > budget) begin timeout("row_done"); break; end
    end
    pix_ready = 1;
  endtask

  initial begin
    int n;
    rst_n = 0; req_valid = 0; req_addr = '0; pix_ready = 1;
    req_valid3 = 0; req_addr3 = '0; pix_ready3 = 1;

    // 1: reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, 1);
    check("rst_pix_valid", pix_valid, 0);
    check("rst_rom_addr", rom_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_pix_bit", pix_bit, 0);
    check("rst_pix_last", pix_last, 0);
    check("rst_pix_valid3", pix_valid3, 0);
    rst_n = 1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_req_ready", req_ready, 1);
    check("idle_busy", busy, 0);

    // 2: row 5, SCALE=1, no stalls
    hs1 = 0; last1 = 0;
    send(1, 12'd5);
    check("rom_addr_row5", rom_addr, 5);
    check("busy_row5", busy, 1);
    check("req_ready_busy", req_ready, 0);
    wait_idle(1, 0, 400);
    check("first_valid_latency", fv_edge1 - acc_edge1, 2);
    check("hs_row5", hs1, 96);
    check("last_row5", last1, 1);
    check("ready_after_last", req_ready, 1);
    check("idle_edge_after_last", cyc, last_edge1);
    check("rom_addr_hold", rom_addr, 5);

    // 3: row 7 with pix_ready toggling every cycle
    hs1 = 0; last1 = 0;
    send(1, 12'd7);
    wait_idle(1, 1, 800);
    check("hs_row7_toggle", hs1, 96);
    check("last_row7_toggle", last1, 1);

    // 4: SCALE=3, row 5
    hs3 = 0; last3 = 0;
    send(3, 12'd5);
    wait_idle(3, 0, 1000);
    check("hs_scale3", hs3, 288);
    check("last_scale3", last3, 1);

    // 5: request held during SHIFT is ignored, then accepted right after last handshake
    hs1 = 0; last1 = 0;
    send(1, 12'd5);
    n = 0;
    while (!pix_valid) begin
      @(posedge clk); #1;
      if (++n > 20) begin timeout("shift_entry"); break; end
    end
    push_row(1, 12'd7, 1);
    acc_seen1 = 0; req_addr = 12'd7; req_valid = 1;
    n = 0;
    forever begin
      @(posedge clk); #1;
      if (acc_seen1) break;
      if (++n > 300) begin timeout("held_accept"); break; end
    end
    req_valid = 0;
    check("accept_after_last", acc_edge1, last_edge1 + 1);
    check("rom_addr_row7", rom_addr, 7);
    wait_idle(1, 0, 400);
    check("last_two_rows", last1, 2);

    // 6: reset during emission 40 of row 7
    hs1 = 0; last1 = 0;
    send(1, 12'd7);
    n = 0;
    while (hs1 < 39) begin
      @(posedge clk); #1;
      if (++n > 200) begin timeout("reach_emission40"); break; end
    end
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    q1.delete();
    check("midrst_pix_valid", pix_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_req_ready", req_ready, 1);
    check("midrst_rom_addr", rom_addr, 0);
    check("midrst_no_last", last1, 0);
    repeat (6) @(posedge clk);
    #1;
    check("midrst_stays_idle", pix_valid, 0);
    check("midrst_no_last_later", last1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
